// File: rtl/id_ex_pipeline_pkg.sv
// Shared types for the decode/execute boundary: widths, control bundle
// and the operand-forwarding select encoding.
package proc_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [3:0] alu_op;
    } ctrl_t;

    typedef enum logic [2:0] {
        FWD_ZERO,
        FWD_EX,
        FWD_MEM,
        FWD_WB,
        FWD_RF
    } fwd_sel_t;

endpackage

// File: rtl/id_ex_pipeline_operand_forward.sv
// Per-operand forwarding mux, youngest writer first; x0 always reads 0.
// Ports: rs/rf_data in; ex/mem/wb enable+rd+data in; data, sel out.
module operand_forward
    import proc_pkg::*;
#(
    parameter int DATA_W = proc_pkg::DATA_W,
    parameter int ADDR_W = proc_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] rs,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              ex_en,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              mem_en,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data,
    output fwd_sel_t          sel
);

    always_comb begin
        sel = FWD_RF;
        if (rs == '0)
            sel = FWD_ZERO;
        else if (ex_en && ex_rd == rs)
            sel = FWD_EX;
        else if (mem_en && mem_rd == rs)
            sel = FWD_MEM;
        else if (wb_en && wb_rd == rs)
            sel = FWD_WB;
    end

    always_comb begin
        data = rf_data;
        unique case (sel)
            FWD_ZERO: data = '0;
            FWD_EX:   data = ex_data;
            FWD_MEM:  data = mem_data;
            FWD_WB:   data = wb_data;
            FWD_RF:   data = rf_data;
            default:  data = rf_data;
        endcase
    end

endmodule

// File: rtl/id_ex_pipeline.sv
// ID/EX pipeline register with RAW hazard resolution (forward or stall),
// load-use bubble, back-pressure and flush.
// Ports: id_* decode side (valid/ready), mem_*/wb_* writer taps,
// flush, ex_ready in; ex_* registered bundle out.
// Build option: define ID_EX_FORWARD_EN to forward from EX/MEM/WB;
// otherwise any pending writer of a source register stalls decode.
module id_ex_pipeline
    import proc_pkg::*;
#(
    parameter int DATA_W = proc_pkg::DATA_W,
    parameter int ADDR_W = proc_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [31:0]       id_pc,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  ctrl_t             id_ctrl,
    input  logic [DATA_W-1:0] ex_fwd_data,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [DATA_W-1:0] mem_fwd_data,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [ADDR_W-1:0] ex_rd,
    output ctrl_t             ex_ctrl
);

    logic              ex_valid_q, ex_valid_d;
    logic [31:0]       ex_pc_q, ex_pc_d;
    logic [DATA_W-1:0] ex_op1_q, ex_op1_d;
    logic [DATA_W-1:0] ex_op2_q, ex_op2_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    logic [ADDR_W-1:0] ex_rd_q, ex_rd_d;
    ctrl_t             ex_ctrl_q, ex_ctrl_d;

    logic              advance;
    logic              load_use;
    logic              raw_stall;
    logic              stall;
    logic              ex_fwd_en;
    logic              mem_fwd_en;
    logic              wb_fwd_en;
    logic [DATA_W-1:0] op1_fwd;
    logic [DATA_W-1:0] op2_fwd;
    fwd_sel_t          sel1;
    fwd_sel_t          sel2;

    always_comb begin
        advance  = ex_ready | ~ex_valid_q;
        load_use = id_valid & ex_valid_q & ex_ctrl_q.mem_read
                 & (ex_rd_q != '0)
                 & ((ex_rd_q == id_rs1) | (ex_rd_q == id_rs2));
`ifdef ID_EX_FORWARD_EN
        // A held load has no result yet; load_use covers it instead.
        ex_fwd_en  = ex_valid_q & ex_ctrl_q.reg_write
                   & ~ex_ctrl_q.mem_read;
        mem_fwd_en = mem_reg_write;
        wb_fwd_en  = wb_reg_write;
        raw_stall  = 1'b0;
`else
        ex_fwd_en  = 1'b0;
        mem_fwd_en = 1'b0;
        wb_fwd_en  = 1'b0;
        raw_stall  = id_valid & (
              (ex_valid_q & ex_ctrl_q.reg_write & (ex_rd_q != '0)
               & ((ex_rd_q == id_rs1) | (ex_rd_q == id_rs2)))
            | (mem_reg_write & (mem_rd != '0)
               & ((mem_rd == id_rs1) | (mem_rd == id_rs2)))
            | (wb_reg_write & (wb_rd != '0)
               & ((wb_rd == id_rs1) | (wb_rd == id_rs2))));
`endif
        stall    = load_use | raw_stall;
        id_ready = advance & ~stall & ~flush;
    end

    operand_forward #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd1 (
        .rs       (id_rs1),
        .rf_data  (id_rdata1),
        .ex_en    (ex_fwd_en),
        .ex_rd    (ex_rd_q),
        .ex_data  (ex_fwd_data),
        .mem_en   (mem_fwd_en),
        .mem_rd   (mem_rd),
        .mem_data (mem_fwd_data),
        .wb_en    (wb_fwd_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .data     (op1_fwd),
        .sel      (sel1)
    );

    operand_forward #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd2 (
        .rs       (id_rs2),
        .rf_data  (id_rdata2),
        .ex_en    (ex_fwd_en),
        .ex_rd    (ex_rd_q),
        .ex_data  (ex_fwd_data),
        .mem_en   (mem_fwd_en),
        .mem_rd   (mem_rd),
        .mem_data (mem_fwd_data),
        .wb_en    (wb_fwd_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .data     (op2_fwd),
        .sel      (sel2)
    );

    // x0 must never pick up a writer's value.
    always_comb begin
        if (rst_n) begin
            assert (sel1 != FWD_ZERO || op1_fwd == '0);
            assert (sel2 != FWD_ZERO || op2_fwd == '0);
        end
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_pc_d    = ex_pc_q;
        ex_op1_d   = ex_op1_q;
        ex_op2_d   = ex_op2_q;
        ex_imm_d   = ex_imm_q;
        ex_rd_d    = ex_rd_q;
        ex_ctrl_d  = ex_ctrl_q;
        if (flush || (advance && (stall || !id_valid))) begin
            ex_valid_d = 1'b0;
            ex_pc_d    = '0;
            ex_op1_d   = '0;
            ex_op2_d   = '0;
            ex_imm_d   = '0;
            ex_rd_d    = '0;
            ex_ctrl_d  = '0;
        end else if (advance) begin
            ex_valid_d = 1'b1;
            ex_pc_d    = id_pc;
            ex_op1_d   = op1_fwd;
            ex_op2_d   = op2_fwd;
            ex_imm_d   = id_imm;
            ex_rd_d    = id_rd;
            ex_ctrl_d  = id_ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_pc_q    <= '0;
            ex_op1_q   <= '0;
            ex_op2_q   <= '0;
            ex_imm_q   <= '0;
            ex_rd_q    <= '0;
            ex_ctrl_q  <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_pc_q    <= ex_pc_d;
            ex_op1_q   <= ex_op1_d;
            ex_op2_q   <= ex_op2_d;
            ex_imm_q   <= ex_imm_d;
            ex_rd_q    <= ex_rd_d;
            ex_ctrl_q  <= ex_ctrl_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_pc    = ex_pc_q;
    assign ex_op1   = ex_op1_q;
    assign ex_op2   = ex_op2_q;
    assign ex_imm   = ex_imm_q;
    assign ex_rd    = ex_rd_q;
    assign ex_ctrl  = ex_ctrl_q;

endmodule

// File: tb/tb_id_ex_pipeline.sv
// Directed vector bench for id_ex_pipeline: a mode-independent table
// plus hand-built sequences for hazards, reset, hold and flush.
module tb_id_ex_pipeline;
    import proc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rdata1, id_rdata2, id_imm;
    ctrl_t       id_ctrl;
    logic [31:0] ex_fwd_data;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic [31:0] mem_fwd_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
    logic [4:0]  ex_rd;
    ctrl_t       ex_ctrl;

    id_ex_pipeline dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
        .id_imm(id_imm), .id_ctrl(id_ctrl),
        .ex_fwd_data(ex_fwd_data),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_fwd_data(mem_fwd_data),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .flush(flush), .ex_ready(ex_ready),
        .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_ctrl(ex_ctrl)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        idv;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2;
        logic        rw, ld;
        logic [31:0] exf;
        logic [4:0]  mrd;
        logic        mwe;
        logic [31:0] mdata;
        logic [4:0]  wrd;
        logic        wwe;
        logic [31:0] wdata;
        logic        exr, fl;
        logic        erdy, ev;
        logic [31:0] e1, e2;
        logic [4:0]  erd;
    } vec_t;

    int    n_chk = 0;
    int    n_fail = 0;
    int    seq = 0;
    logic [31:0] exp_pc;
    ctrl_t       exp_ctrl;
    vec_t  tbl [10];
    vec_t  v;

    function automatic vec_t mk(
        logic idv, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
        logic [31:0] d1, logic [31:0] d2, logic rw, logic ld,
        logic exr, logic fl, logic erdy, logic ev,
        logic [31:0] e1, logic [31:0] e2, logic [4:0] erd);
        vec_t r;
        r.idv = idv; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
        r.d1 = d1; r.d2 = d2; r.rw = rw; r.ld = ld;
        r.exf = 32'h0; r.mrd = 5'd0; r.mwe = 1'b0; r.mdata = 32'h0;
        r.wrd = 5'd0; r.wwe = 1'b0; r.wdata = 32'h0;
        r.exr = exr; r.fl = fl; r.erdy = erdy; r.ev = ev;
        r.e1 = e1; r.e2 = e2; r.erd = erd;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input string nm);
        ctrl_t c;
        @(negedge clk);
        seq++;
        c = '0;
        c.reg_write = t.rw;
        c.mem_read  = t.ld;
        c.alu_op    = seq[3:0];
        c.alu_src   = seq[0];
        id_valid = t.idv; id_rs1 = t.rs1; id_rs2 = t.rs2; id_rd = t.rd;
        id_rdata1 = t.d1; id_rdata2 = t.d2;
        id_pc = 32'h100 + 32'(seq * 4); id_imm = 32'(seq);
        id_ctrl = c;
        ex_fwd_data = t.exf;
        mem_rd = t.mrd; mem_reg_write = t.mwe; mem_fwd_data = t.mdata;
        wb_rd = t.wrd; wb_reg_write = t.wwe; wb_data = t.wdata;
        ex_ready = t.exr; flush = t.fl;
        #1;
        chk({nm, ".id_ready"}, 32'(id_ready), 32'(t.erdy));
        if (t.erdy && t.idv) begin
            exp_pc = id_pc;
            exp_ctrl = c;
        end
        @(posedge clk);
        #1;
        chk({nm, ".ex_valid"}, 32'(ex_valid), 32'(t.ev));
        if (t.ev) begin
            chk({nm, ".ex_op1"}, ex_op1, t.e1);
            chk({nm, ".ex_op2"}, ex_op2, t.e2);
            chk({nm, ".ex_rd"}, 32'(ex_rd), 32'(t.erd));
            chk({nm, ".ex_pc"}, ex_pc, exp_pc);
            chk({nm, ".ex_ctrl"}, 32'(ex_ctrl), 32'(exp_ctrl));
        end else begin
            chk({nm, ".bub_ctrl"}, 32'(ex_ctrl), 32'h0);
            chk({nm, ".bub_rd"}, 32'(ex_rd), 32'h0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rdata1 = 0; id_rdata2 = 0; id_pc = 0; id_imm = 0;
        id_ctrl = '0; ex_fwd_data = 0; mem_rd = 0; mem_reg_write = 0;
        mem_fwd_data = 0; wb_rd = 0; wb_reg_write = 0; wb_data = 0;
        flush = 0; ex_ready = 1;
        exp_pc = 0; exp_ctrl = '0;

        tbl[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        tbl[1] = mk(1, 3, 4, 8, 32'h11, 32'h22, 1, 0, 1, 0,
                    1, 1, 32'h11, 32'h22, 8);
        tbl[2] = mk(1, 0, 0, 0, 32'hdead, 32'hbeef, 0, 0, 1, 0,
                    1, 1, 0, 0, 0);
        tbl[2].mwe = 1; tbl[2].mdata = 32'h55;
        tbl[2].wwe = 1; tbl[2].wdata = 32'h66;
        tbl[3] = mk(1, 1, 2, 10, 32'h1234, 32'h5678, 1, 1, 1, 0,
                    1, 1, 32'h1234, 32'h5678, 10);
        tbl[3].mrd = 1; tbl[3].mdata = 32'hbad;
        tbl[3].wrd = 2; tbl[3].wdata = 32'hbad;
        tbl[4] = mk(0, 0, 10, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        tbl[5] = mk(1, 10, 11, 12, 32'h77, 32'h88, 1, 0, 1, 0,
                    1, 1, 32'h77, 32'h88, 12);
        tbl[6] = mk(1, 5, 6, 13, 1, 2, 1, 0, 0, 0,
                    0, 1, 32'h77, 32'h88, 12);
        tbl[7] = mk(1, 5, 6, 13, 1, 2, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[8] = mk(1, 5, 6, 13, 1, 2, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        tbl[9] = mk(1, 21, 22, 14, 32'habc, 32'hdef, 1, 0, 1, 0,
                    1, 1, 32'habc, 32'hdef, 14);
        tbl[9].mrd = 23; tbl[9].mwe = 1; tbl[9].mdata = 32'h1;
        tbl[9].wrd = 20; tbl[9].wwe = 1; tbl[9].wdata = 32'hfff;

        repeat (2) @(posedge clk);
        #1;
        chk("reset.ex_valid", 32'(ex_valid), 32'h0);
        chk("reset.ex_ctrl", 32'(ex_ctrl), 32'h0);
        chk("reset.ex_op1", ex_op1, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        // asynchronous reset while a valid instruction is held
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.ex_valid", 32'(ex_valid), 32'h0);
        chk("midrst.ex_ctrl", 32'(ex_ctrl), 32'h0);
        chk("midrst.ex_op1", ex_op1, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // load-use: load r7, then consumer of r7 in rs2
        apply(mk(1, 1, 2, 7, 0, 0, 1, 1, 1, 0, 1, 1, 0, 0, 7), "lu_load");
        apply(mk(1, 3, 7, 15, 32'h31, 32'h44, 1, 0, 1, 0,
                 0, 0, 0, 0, 0), "lu_stall");
        v = mk(1, 3, 7, 15, 32'h31, 32'h44, 1, 0, 1, 0,
               1, 1, 32'h31, 32'h99, 15);
        v.mrd = 7; v.mwe = 1; v.mdata = 32'h99;
`ifdef ID_EX_FORWARD_EN
        apply(v, "lu_memfwd");
`else
        v.erdy = 0; v.ev = 0;
        apply(v, "lu_memstall");
        v.mwe = 0; v.wrd = 7; v.wwe = 1; v.wdata = 32'h99;
        apply(v, "lu_wbstall");
        v = mk(1, 3, 7, 15, 32'h31, 32'h99, 1, 0, 1, 0,
               1, 1, 32'h31, 32'h99, 15);
        apply(v, "lu_rf");
`endif

        // priority: EX over MEM over WB over register file
        apply(mk(1, 0, 0, 5, 0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 5), "pr_w5");
        v = mk(1, 5, 0, 6, 32'h1, 0, 1, 0, 1, 0, 1, 1, 32'ha, 0, 6);
        v.exf = 32'ha;
        v.mrd = 5; v.mwe = 1; v.mdata = 32'hb;
        v.wrd = 5; v.wwe = 1; v.wdata = 32'hc;
`ifndef ID_EX_FORWARD_EN
        v.erdy = 0; v.ev = 0;
`endif
        apply(v, "pr_ex");
        v.e1 = 32'hb;
        apply(v, "pr_mem");
        v.mwe = 0; v.e1 = 32'hc;
        apply(v, "pr_wb");
        v.wwe = 0; v.e1 = 32'h1; v.erdy = 1; v.ev = 1;
        apply(v, "pr_rf");

        // back-pressure for three cycles, then retire and accept
        apply(mk(1, 0, 0, 16, 0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 16), "bp_cap");
        v = mk(1, 3, 4, 17, 5, 6, 1, 0, 0, 0, 0, 1, 0, 0, 16);
        for (int k = 0; k < 3; k++)
            apply(v, $sformatf("bp_hold%0d", k));
        v = mk(1, 3, 4, 17, 5, 6, 1, 0, 1, 0, 1, 1, 5, 6, 17);
        apply(v, "bp_go");
        v = mk(1, 3, 4, 18, 5, 6, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        apply(v, "bp_flush");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
